// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone memory arbiter.
// FSM state encoding and Wishbone cycle-type identifiers.
package wb_arb_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Round-robin winner selection: searches upward from last_i+1 (mod N)
// and returns the first requester as a one-hot vector.
module wb_arb_rr_pick #(
    parameter int N  = 2,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    logic [LW-1:0] idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = LW'((int'(last_i) + i) % N);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory slave among NUM_MASTERS.
// Define WB_MEM_ARBITER_WATCHDOG_EN to add the stalled-strobe watchdog.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS*aw-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*dw-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [NUM_MASTERS*dw-1:0] wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [aw-1:0]             wbs_adr_o,
    output logic [dw-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [dw-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i
);

    localparam int LW = $clog2(NUM_MASTERS);

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0]          owner_q, owner_d;
    logic [LW-1:0]          last_q, last_d;
    logic [NUM_MASTERS-1:0] pick;
    logic                   granted;
    logic                   timeout;

    wb_arb_rr_pick #(
        .N  (NUM_MASTERS),
        .LW (LW)
    ) u_pick (
        .req_i  (wbm_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|wbm_cyc_i) begin
                    state_d = ST_GRANT;
                    grant_d = pick;
                    for (int k = 0; k < NUM_MASTERS; k++) begin
                        if (pick[k]) owner_d = LW'(k);
                    end
                end
            end
            ST_GRANT: begin
                if (!wbm_cyc_i[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Reset gates the outputs directly so they drop in the same cycle.
    assign granted = (state_q == ST_GRANT) && !wb_rst_i;

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (granted) begin
            wbs_adr_o = wbm_adr_i[int'(owner_q)*aw +: aw];
            wbs_dat_o = wbm_dat_i[int'(owner_q)*dw +: dw];
            wbs_sel_o = wbm_sel_i[int'(owner_q)*4 +: 4];
            wbs_we_o  = wbm_we_i[owner_q];
            wbs_cyc_o = wbm_cyc_i[owner_q];
            wbs_stb_o = wbm_stb_i[owner_q] & ~timeout;
            wbs_cti_o = wbm_cti_i[int'(owner_q)*3 +: 3];
            wbs_bte_o = wbm_bte_i[int'(owner_q)*2 +: 2];
        end
    end

    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign wbm_ack_o = grant_q & {NUM_MASTERS{granted & wbs_ack_i}};
    assign wbm_err_o = grant_q & {NUM_MASTERS{granted & (wbs_err_i | timeout)}};
    assign wbm_rty_o = grant_q & {NUM_MASTERS{granted & wbs_rty_i}};

`ifdef WB_MEM_ARBITER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          slave_resp;

    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign timeout    = granted && (wd_q == WW'(TIMEOUT));

    always_comb begin
        wd_d = wd_q + WW'(1);
        if (timeout || !granted || !wbs_stb_o || slave_resp) wd_d = '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wd_q <= '0;
        else          wd_q <= wd_d;
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed testbench for wb_mem_arbiter: two masters, TIMEOUT=8,
// slave responses driven by hand from each scenario task.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

`ifdef WB_MEM_ARBITER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] wbm_adr_i, wbm_dat_i;
    logic [7:0]  wbm_sel_i;
    logic [1:0]  wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [5:0]  wbm_cti_i;
    logic [3:0]  wbm_bte_i;
    logic [63:0] wbm_dat_o;
    logic [1:0]  wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

    int errors;
    int checks;

    wb_mem_arbiter #(
        .NUM_MASTERS (2),
        .dw          (32),
        .aw          (32),
        .TIMEOUT     (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i),
        .wbm_bte_i (wbm_bte_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic cyc, input logic stb,
                       input logic we, input logic [2:0] cti,
                       input logic [31:0] adr);
        wbm_cyc_i[k]          = cyc;
        wbm_stb_i[k]          = stb;
        wbm_we_i[k]           = we;
        wbm_cti_i[k*3 +: 3]   = cti;
        wbm_adr_i[k*32 +: 32] = adr;
        wbm_dat_i[k*32 +: 32] = adr ^ 32'hFFFF_0000;
        wbm_sel_i[k*4 +: 4]   = 4'hF;
        wbm_bte_i[k*2 +: 2]   = 2'b00;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        drv(0, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_1000);
        wbs_ack_i = 1'b1;
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_cyc_stb got %b%b want 00", wbs_cyc_o, wbs_stb_o);
        end
        checks++;
        if (wbm_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL rst_ack got %b want 00", wbm_ack_o);
        end
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        wbs_ack_i = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbs_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL idle_out got cyc=%b adr=%h want 0/0", wbs_cyc_o, wbs_adr_o);
        end
    endtask

    task automatic test_same_cycle();
        drv(0, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_1000);
        drv(1, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_2000);
        #1;
        checks++;
        if (wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL arb_latency got %b want 0", wbs_cyc_o);
        end
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_1000) begin
            errors++;
            $display("FAIL first_m0 got cyc=%b adr=%h want 1/00001000", wbs_cyc_o, wbs_adr_o);
        end
        checks++;
        if (wbs_dat_o !== 32'hFFFF_1000) begin
            errors++;
            $display("FAIL wdat_mux got %h want ffff1000", wbs_dat_o);
        end
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hCAFE_0001;
        #1;
        checks++;
        if (wbm_ack_o !== 2'b01) begin
            errors++;
            $display("FAIL ack_m0 got %b want 01", wbm_ack_o);
        end
        checks++;
        if (wbm_dat_o !== 64'hCAFE_0001_CAFE_0001) begin
            errors++;
            $display("FAIL rdat_bcast got %h want cafe0001cafe0001", wbm_dat_o);
        end
        tick();
        wbs_ack_i = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbs_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL idle_gap got cyc=%b adr=%h want 0/0", wbs_cyc_o, wbs_adr_o);
        end
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_2000) begin
            errors++;
            $display("FAIL second_m1 got cyc=%b adr=%h want 1/00002000", wbs_cyc_o, wbs_adr_o);
        end
        wbs_ack_i = 1'b1;
        #1;
        checks++;
        if (wbm_ack_o !== 2'b10) begin
            errors++;
            $display("FAIL ack_m1 got %b want 10", wbm_ack_o);
        end
        tick();
        wbs_ack_i = 1'b0;
        drv(1, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
    endtask

    task automatic test_burst();
        logic [2:0]  cti;
        logic [31:0] adr;
        drv(1, 1'b1, 1'b1, 1'b0, CTI_INC, 32'h0000_3000);
        tick();
        drv(0, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_4000);
        for (int b = 0; b < 4; b++) begin
            cti = (b == 3) ? CTI_EOB : CTI_INC;
            adr = 32'h0000_3000 + 32'(4 * b);
            drv(1, 1'b1, 1'b1, 1'b0, cti, adr);
            wbs_ack_i = 1'b1;
            #1;
            checks++;
            if (wbm_ack_o !== 2'b10) begin
                errors++;
                $display("FAIL burst_ack beat %0d got %b want 10", b, wbm_ack_o);
            end
            checks++;
            if (wbs_adr_o !== adr || wbs_cti_o !== cti) begin
                errors++;
                $display("FAIL burst_mux beat %0d got %h/%b want %h/%b",
                         b, wbs_adr_o, wbs_cti_o, adr, cti);
            end
            tick();
        end
        wbs_ack_i = 1'b0;
        drv(1, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap got %b want 0", wbs_cyc_o);
        end
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_4000) begin
            errors++;
            $display("FAIL burst_handoff got cyc=%b adr=%h want 1/00004000", wbs_cyc_o, wbs_adr_o);
        end
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic        stb;
        logic [31:0] adr;
        drv(0, 1'b1, 1'b1, 1'b1, CTI_CLASSIC, 32'h0000_5000);
        tick();
        drv(1, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_6000);
        for (int c = 0; c < 6; c++) begin
            stb = (c % 2 == 0);
            adr = 32'h0000_5000 + 32'(4 * c);
            drv(0, 1'b1, stb, 1'b1, CTI_CLASSIC, adr);
            wbs_ack_i = stb;
            #1;
            checks++;
            if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== adr || wbs_we_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_hold cyc %0d got cyc=%b adr=%h we=%b want 1/%h/1",
                         c, wbs_cyc_o, wbs_adr_o, wbs_we_o, adr);
            end
            checks++;
            if (wbm_ack_o !== {1'b0, stb}) begin
                errors++;
                $display("FAIL b2b_ack cyc %0d got %b want %b", c, wbm_ack_o, {1'b0, stb});
            end
            tick();
        end
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b1;
        wbs_rty_i = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b1, CTI_CLASSIC, 32'h0000_5100);
        #1;
        checks++;
        if (wbm_err_o !== 2'b01 || wbm_rty_o !== 2'b01) begin
            errors++;
            $display("FAIL err_rty_route got %b/%b want 01/01", wbm_err_o, wbm_rty_o);
        end
        tick();
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got %b want 0", wbs_cyc_o);
        end
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_6000) begin
            errors++;
            $display("FAIL b2b_release got cyc=%b adr=%h want 1/00006000", wbs_cyc_o, wbs_adr_o);
        end
        drv(1, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
    endtask

    task automatic test_withdraw();
        drv(0, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_1111);
        #4;
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
        drv(1, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_7000);
        #1;
        checks++;
        if (wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle got %b want 0", wbs_cyc_o);
        end
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_7000) begin
            errors++;
            $display("FAIL glitch_ignored got cyc=%b adr=%h want 1/00007000", wbs_cyc_o, wbs_adr_o);
        end
        drv(1, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_burst();
        drv(1, 1'b1, 1'b1, 1'b0, CTI_INC, 32'h0000_8000);
        tick();
        drv(0, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_9000);
        wbs_ack_i = 1'b1;
        #1;
        checks++;
        if (wbm_ack_o !== 2'b10) begin
            errors++;
            $display("FAIL mid_ack got %b want 10", wbm_ack_o);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || wbm_ack_o !== 2'b00) begin
            errors++;
            $display("FAIL mid_rst got cyc=%b stb=%b ack=%b want 0/0/00",
                     wbs_cyc_o, wbs_stb_o, wbm_ack_o);
        end
        tick();
        rst = 1'b0;
        wbs_ack_i = 1'b0;
        #1;
        checks++;
        if (wbs_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle got %b want 0", wbs_cyc_o);
        end
        tick();
        checks++;
        if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_9000) begin
            errors++;
            $display("FAIL post_rst_m0 got cyc=%b adr=%h want 1/00009000", wbs_cyc_o, wbs_adr_o);
        end
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        repeat (2) tick();
    endtask

    task automatic test_watchdog();
        logic [1:0] exp_err;
        logic       exp_stb;
        drv(0, 1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0000_A000);
        tick();
        for (int c = 0; c < 11; c++) begin
            exp_err = {1'b0, WD && (c == 8)};
            exp_stb = !(WD && (c == 8));
            checks++;
            if (wbm_err_o !== exp_err || wbs_stb_o !== exp_stb) begin
                errors++;
                $display("FAIL watchdog cyc %0d got err=%b stb=%b want %b/%b",
                         c, wbm_err_o, wbs_stb_o, exp_err, exp_stb);
            end
            tick();
        end
        drv(0, 1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
        wbm_we_i  = '0;
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
        wbm_cti_i = '0;
        wbm_bte_i = '0;
        wbs_dat_i = '0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
        test_reset();
        test_same_cycle();
        test_burst();
        test_back_to_back();
        test_withdraw();
        test_reset_mid_burst();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
